jtpang_bank_resp: RTL and testbench
===================================

// Module: jtpang_bank_resp
// PURPOSE
//  Responder end of the 4-bank SDRAM request handshake (ba*_addr/ba_rd -> ba_ack/dst/dok/rdy/data_read).
//  Arbitrates the four bank read requests and turns each into a burst on a fixed-latency memory read port.
//  Sits between the game's jtpang_sdram client and the memory model or simple controller.
//  Doubles as the bench-side SDRAM stand-in for game-level simulation.
// PARAMETERS
//  AW     22  bank word-address width
//  BURST  2   words returned per request (1..4)
//  LAT    3   cycles from mem_rd to valid mem_data (1..8)
// PORTS
//  clk        in   1      system clock, single domain
//  rst_n      in   1      synchronous reset, active low
//  ba_addr    in   4*AW   packed bank addresses; bank k at [k*AW +: AW]
//  ba_rd      in   4      per-bank read request, level
//  ba_ack     out  4      one-cycle grant pulse, address latched this cycle
//  ba_dst     out  4      one-cycle pulse with first data word
//  ba_dok     out  4      high on every cycle data_read is valid for that bank
//  ba_rdy     out  4      one-cycle pulse with last data word
//  data_read  out  16     returned word, shared by all banks
//  mem_addr   out  AW+2   {bank[1:0], word address} to memory
//  mem_rd     out  1      memory read strobe, one word per cycle
//  mem_data   in   16     memory data, valid exactly LAT cycles after mem_rd
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, round-robin pointer=0. Applies mid-burst too.
//   In-flight words are discarded and no dst/dok/rdy is emitted for them.
//  FSM states:
//   IDLE -> GRANT when any ba_rd is high (registered decision).
//   GRANT (1 cycle): ba_ack[k]=1; latch ba_addr[k] and k -> ISSUE.
//   ISSUE (BURST cycles): mem_rd=1, mem_addr={k,addr+i}, i=0..BURST-1 -> DRAIN.
//   DRAIN: wait for the last word to return -> IDLE.
//  Return path: LAT-deep shift of {valid,first,last}, aligned with mem_data.
//   When valid: data_read<=mem_data, ba_dok[k]=1.
//   ba_dst[k] pulses with the first word; ba_rdy[k] pulses with the last word.
//   BURST=1: dst and rdy pulse in the same cycle.
//  Timing, with ack at cycle T:
//   mem_rd at T+1..T+BURST.
//   First dok/dst at T+1+LAT (mem_data is registered into data_read).
//   rdy at T+LAT+BURST.
//   IDLE is re-entered the cycle after rdy; the earliest next ack is 2 cycles after rdy.
//  data_read holds its last value when no word is valid; dok=0.
//  Arbitration: round robin. Search starts at bank (last_granted+1) mod 4.
//   If several ba_rd are high in the same cycle, the first bank found in that order wins.
//  ba_rd sampled only in IDLE.
//   A request dropped before ack is never served.
//   Dropping ba_rd after ack does not abort the burst.
//   A bank holding ba_rd high after rdy is re-granted only per round robin, so no bank starves.
//  Address increment wraps modulo 2^AW; the bank bits never change within a burst.
//  Only one request is outstanding at a time, so ack/dst/dok/rdy are one-hot or zero.
// CONFIGURATION
//  JTPANG_BANK_PRIO_EN defined: fixed priority, bank 0 highest and bank 3 lowest; pointer unused.
//  JTPANG_BANK_PRIO_EN undefined (default): round robin as above.
// TESTING
//  1. rst_n=0 for 4 cycles during an active burst -> all outputs 0; no dok after release; first ack 2 cycles after a new ba_rd.
//  2. ba_rd=4'b0001, addr0=22'h3FFFFF, BURST=2, LAT=3
//     -> ack[0] at T; mem_addr 24'h3FFFFF then 24'h000000 (wrap, bank bits 0);
//     dst[0]+dok[0] at T+4; rdy[0]+dok[0] at T+5.
//  3. ba_rd=4'b1111 held high -> grant order 0,1,2,3,0 (round robin).
//     With JTPANG_BANK_PRIO_EN: 0,0,0 while ba_rd[0] stays high.
//  4. ba_rd[2] pulsed 1 cycle while a bank-1 burst is active -> bank 2 never acked.
//     ba_rd[1] dropped right after its ack -> bank-1 burst still completes with rdy[1].
//  5. Memory returns words 16'hA5A5,16'h5A5A for bank 3
//     -> data_read shows them on consecutive dok[3] cycles; ba_dok is one-hot throughout.
//  6. BURST=1 -> dst and rdy for the bank asserted in the same cycle as its single dok.

Source files
------------

// File: rtl/jtpang_bank_resp.sv
// Four-bank SDRAM read responder: arbitrates bank requests and streams bursts from a fixed-latency port.
// Define JTPANG_BANK_PRIO_EN for fixed priority (bank 0 highest); the default is round robin.
module jtpang_bank_resp #(
    parameter int AW    = 22,
    parameter int BURST = 2,
    parameter int LAT   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*AW-1:0]   ba_addr,
    input  logic [3:0]        ba_rd,
    output logic [3:0]        ba_ack,
    output logic [3:0]        ba_dst,
    output logic [3:0]        ba_dok,
    output logic [3:0]        ba_rdy,
    output logic [15:0]       data_read,
    output logic [AW+1:0]     mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_data
);

    typedef enum logic [1:0] {IDLE, GRANT, ISSUE, DRAIN} state_t;

    state_t            state, state_nx;
    logic [1:0]        win;
    logic [1:0]        bank_q;
    logic [3:0]        bank_oh;
    logic [AW-1:0]     addr_q;
    logic [1:0]        beat;
    logic              last_beat;
    logic [2:0]        tag_now;
    logic [2:0]        ret;
    logic [3*LAT-1:0]  sr_q;
    logic [3*LAT+2:0]  hist;

`ifdef JTPANG_BANK_PRIO_EN
    always_comb begin
        win = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (ba_rd[i-1]) win = 2'(i-1);
        end
    end
`else
    logic [1:0] ptr_q;

    // Scan from the farthest offset down so the nearest requester after ptr_q wins.
    always_comb begin
        win = ptr_q;
        for (int unsigned i = 4; i > 0; i--) begin
            if (ba_rd[ptr_q + 2'(i-1)]) win = ptr_q + 2'(i-1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            ptr_q <= '0;
        else if (state == GRANT)
            ptr_q <= bank_q + 2'd1;
    end
`endif

    assign bank_oh   = 4'b0001 << bank_q;
    assign last_beat = (beat == 2'(BURST-1));

    // hist slot j holds the {valid,first,last} tag of the beat issued j cycles ago;
    // mem_data for a beat is sampled on the LAT-th edge after its mem_rd.
    always_comb begin
        tag_now  = {state == ISSUE, beat == 2'd0, last_beat};
        hist     = {sr_q, tag_now};
        ret      = hist[3*(LAT-1) +: 3];
        ba_ack   = (state == GRANT) ? bank_oh : '0;
        mem_rd   = (state == ISSUE);
        mem_addr = (state == ISSUE) ? {bank_q, addr_q + AW'(beat)} : '0;
        state_nx = state;
        case (state)
            IDLE:  if (|ba_rd) state_nx = GRANT;
            GRANT: state_nx = ISSUE;
            ISSUE: if (last_beat) state_nx = DRAIN;
            DRAIN: if (hist[3*LAT+2] && hist[3*LAT]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            bank_q    <= '0;
            addr_q    <= '0;
            beat      <= '0;
            sr_q      <= '0;
            ba_dst    <= '0;
            ba_dok    <= '0;
            ba_rdy    <= '0;
            data_read <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE)
                bank_q <= win;
            if (state == GRANT) begin
                addr_q <= ba_addr[32'(bank_q)*AW +: AW];
                beat   <= '0;
            end
            if (state == ISSUE)
                beat <= beat + 2'd1;
            sr_q <= hist[3*LAT-1:0];
            if (ret[2])
                data_read <= mem_data;
            ba_dok <= ret[2] ? bank_oh : '0;
            ba_dst <= (ret[2] && ret[1]) ? bank_oh : '0;
            ba_rdy <= (ret[2] && ret[0]) ? bank_oh : '0;
        end
    end

endmodule

// File: tb/tb_jtpang_bank_resp.sv
// Directed bench for jtpang_bank_resp: default instance (BURST=2, LAT=3) plus a BURST=1, LAT=1 instance.
module tb_jtpang_bank_resp;
    localparam int AW = 22;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [4*AW-1:0] ba_addr, ba_addr1;
    logic [3:0]      ba_rd, ba_rd1;
    logic [3:0]      ba_ack, ba_dst, ba_dok, ba_rdy;
    logic [3:0]      ba_ack1, ba_dst1, ba_dok1, ba_rdy1;
    logic [15:0]     data_read, data_read1, mem_data, mem_data1;
    logic [AW+1:0]   mem_addr, mem_addr1, q0, q1;
    logic            mem_rd, mem_rd1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtpang_bank_resp #(.AW(AW), .BURST(2), .LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .ba_addr(ba_addr), .ba_rd(ba_rd),
        .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
        .data_read(data_read), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data)
    );

    jtpang_bank_resp #(.AW(AW), .BURST(1), .LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ba_addr(ba_addr1), .ba_rd(ba_rd1),
        .ba_ack(ba_ack1), .ba_dst(ba_dst1), .ba_dok(ba_dok1), .ba_rdy(ba_rdy1),
        .data_read(data_read1), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1)
    );

    // Memory contents: bank 3 returns A5A5/5A5A on even/odd words, others addr^0F0F.
    function automatic logic [15:0] mf(input logic [AW+1:0] a);
        if (a[AW+1:AW] == 2'd3) return a[0] ? 16'h5A5A : 16'hA5A5;
        return a[15:0] ^ 16'h0F0F;
    endfunction

    // LAT=3: word sampled on the third edge after mem_rd, i.e. two register stages.
    always @(posedge clk) begin
        q0 <= mem_addr;
        q1 <= q0;
    end
    assign mem_data  = mf(q1);
    assign mem_data1 = mf(mem_addr1);

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(output logic [3:0] who);
        who = '0;
        for (int i = 0; i < 40 && who == 4'd0; i++) begin
            tick;
            who = ba_ack;
        end
        if (who == 4'd0) begin
            total++;
            bad++;
            $error("FAIL ack_timeout observed=0 expected=nonzero");
        end
    endtask

    initial begin
        logic [3:0]  who, seen, acks, rdys;
        logic [3:0]  exp_order [5];
        logic [15:0] d [2];
        int          cyc [2];
        int          n;
        logic        oh_ok;

`ifdef JTPANG_BANK_PRIO_EN
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        rst_n = 1'b0; ba_rd = '0; ba_rd1 = '0; ba_addr = '0; ba_addr1 = '0;
        repeat (3) tick;
        chk("rst_ack",  ba_ack, 4'h0);
        chk("rst_flags", {ba_dst, ba_dok, ba_rdy}, 12'h0);
        chk("rst_mem_rd", mem_rd, 1'b0);
        chk("rst_mem_addr", mem_addr, 24'h0);
        chk("rst_data", data_read, 16'h0);
        rst_n = 1'b1;
        tick;

        // wrap of the word address within bank 0
        ba_addr[0 +: AW] = 22'h3FFFFF;
        ba_rd = 4'b0001;
        tick; chk("t2_ack", ba_ack, 4'b0001);
        ba_rd = '0;
        tick; chk("t2_rd0", mem_rd, 1'b1); chk("t2_addr0", mem_addr, 24'h3FFFFF);
        tick; chk("t2_rd1", mem_rd, 1'b1); chk("t2_addr1", mem_addr, 24'h000000);
        tick; chk("t2_gap_rd", mem_rd, 1'b0); chk("t2_gap_dok", ba_dok, 4'h0);
        tick; chk("t2_dst", ba_dst, 4'b0001); chk("t2_dok0", ba_dok, 4'b0001);
              chk("t2_rdy_early", ba_rdy, 4'h0); chk("t2_data0", data_read, 16'hF0F0);
        tick; chk("t2_rdy", ba_rdy, 4'b0001); chk("t2_dok1", ba_dok, 4'b0001);
              chk("t2_dst_once", ba_dst, 4'h0); chk("t2_data1", data_read, 16'h0F0F);
        tick; chk("t2_dok_end", ba_dok, 4'h0); chk("t2_data_hold", data_read, 16'h0F0F);

        // reset in the middle of a bank-2 burst
        ba_addr[2*AW +: AW] = 22'h000010;
        ba_rd = 4'b0100;
        tick; chk("t1_ack2", ba_ack, 4'b0100);
        ba_rd = '0;
        tick; tick;
        rst_n = 1'b0;
        seen = '0;
        tick; chk("t1_rst_outs", {ba_ack, ba_dst, ba_dok, ba_rdy, 3'b000, mem_rd}, 20'h0);
              chk("t1_rst_data", data_read, 16'h0);
        tick; seen |= ba_dok;
        tick; seen |= ba_dok;
        ba_rd = 4'b0001;
        tick; seen |= ba_dok;
        rst_n = 1'b1;
        chk("t1_ack_early", ba_ack, 4'h0);
        tick; chk("t1_ack_new", ba_ack, 4'b0001);
        ba_rd = '0;
        repeat (3) begin tick; seen |= ba_dok; end
        chk("t1_no_stale_dok", seen, 4'h0);
        repeat (4) tick;

        // all banks requesting continuously
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        ba_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(who);
            chk("t3_grant", who, exp_order[i]);
        end
        ba_rd = '0;
        repeat (10) tick;

        // pulsed and dropped requests
        ba_rd = 4'b0010;
        tick; chk("t4_ack1", ba_ack, 4'b0010);
        ba_rd = '0;
        tick;
        ba_rd = 4'b0100;
        tick;
        acks = ba_ack;
        rdys = ba_rdy;
        ba_rd = '0;
        repeat (12) begin tick; acks |= ba_ack; rdys |= ba_rdy; end
        chk("t4_no_ack2", acks, 4'h0);
        chk("t4_rdy1", rdys, 4'b0010);

        // bank-3 data path
        ba_addr[3*AW +: AW] = 22'h000100;
        ba_rd = 4'b1000;
        wait_ack(who);
        chk("t5_ack3", who, 4'b1000);
        ba_rd = '0;
        n = 0; oh_ok = 1'b1; seen = '0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (!$onehot0(ba_dok)) oh_ok = 1'b0;
            seen |= ba_dok;
            if (ba_dok != 4'h0) begin
                if (n < 2) begin d[n] = data_read; cyc[n] = k; end
                n++;
            end
        end
        chk("t5_count", n, 2);
        chk("t5_onehot", oh_ok, 1'b1);
        chk("t5_bank", seen, 4'b1000);
        if (n >= 2) begin
            chk("t5_word0", d[0], 16'hA5A5);
            chk("t5_word1", d[1], 16'h5A5A);
            chk("t5_consec", cyc[1] - cyc[0], 1);
        end

        // single-word burst
        ba_addr1[2*AW +: AW] = 22'h000055;
        ba_rd1 = 4'b0100;
        tick; chk("t6_ack", ba_ack1, 4'b0100);
        ba_rd1 = '0;
        tick; chk("t6_rd", mem_rd1, 1'b1); chk("t6_addr", mem_addr1, 24'h800055);
        tick; chk("t6_dst", ba_dst1, 4'b0100); chk("t6_rdy", ba_rdy1, 4'b0100);
              chk("t6_dok", ba_dok1, 4'b0100); chk("t6_data", data_read1, 16'h0F5A);
        tick; chk("t6_dok_end", ba_dok1, 4'h0); chk("t6_rdy_end", ba_rdy1, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
